// File: rtl/gx_std_x2_rst_ctrl.sv
// Per-channel TX/RX transceiver reset sequencer gated by calibration, PLL lock and CDR lock-to-data.
// Status inputs: 2-flop sync + 1 FSM cycle to outputs; outputs decode straight from state flops.
module gx_std_x2_rst_ctrl #(
    parameter int NUM_CH       = 2,
    parameter int T_ANALOG_CYC = 8,
    parameter int T_DIG_CYC    = 4,
    parameter int T_LTD_CYC    = 16
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset_n,
    input  logic [NUM_CH-1:0] tx_reset_req,
    input  logic [NUM_CH-1:0] rx_reset_req,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] tx_cal_busy,
    input  logic [NUM_CH-1:0] rx_cal_busy,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    output logic [NUM_CH-1:0] tx_analogreset,
    output logic [NUM_CH-1:0] tx_digitalreset,
    output logic [NUM_CH-1:0] rx_analogreset,
    output logic [NUM_CH-1:0] rx_digitalreset,
    output logic [NUM_CH-1:0] tx_ready,
    output logic [NUM_CH-1:0] rx_ready
);
    localparam int T_MAX0 = (T_ANALOG_CYC > T_DIG_CYC) ? T_ANALOG_CYC : T_DIG_CYC;
    localparam int T_MAX  = (T_MAX0 > T_LTD_CYC) ? T_MAX0 : T_LTD_CYC;
    localparam int CW     = $clog2(T_MAX + 1);
    localparam int SW     = 1 + 3 * NUM_CH;

    typedef enum logic [1:0] {TX_ANA, TX_DIG, TX_RDY} tx_state_t;
    typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_RDY} rx_state_t;

    logic [SW-1:0]     w_async;
    logic [SW-1:0]     r_sync1;
    logic [SW-1:0]     r_sync2;
    logic [NUM_CH-1:0] r_tx_req;
    logic [NUM_CH-1:0] r_rx_req;
    logic              w_pll_s;
    logic [NUM_CH-1:0] w_txcal_s;
    logic [NUM_CH-1:0] w_rxcal_s;
    logic [NUM_CH-1:0] w_ltd_s;

    assign w_async   = {pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata};
    assign w_pll_s   = r_sync2[SW-1];
    assign w_txcal_s = r_sync2[3*NUM_CH-1 -: NUM_CH];
    assign w_rxcal_s = r_sync2[2*NUM_CH-1 -: NUM_CH];
    assign w_ltd_s   = r_sync2[NUM_CH-1:0];

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_tx_req <= '0;
            r_rx_req <= '0;
        end else begin
            r_sync1  <= w_async;
            r_sync2  <= r_sync1;
            r_tx_req <= tx_reset_req;
            r_rx_req <= rx_reset_req;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tx_state_t       r_tx_st;
        tx_state_t       w_tx_st_nxt;
        logic [CW-1:0]   r_tx_cnt;
        logic [CW-1:0]   w_tx_cnt_nxt;
        rx_state_t       r_rx_st;
        rx_state_t       w_rx_st_nxt;
        logic [CW-1:0]   r_rx_cnt;
        logic [CW-1:0]   w_rx_cnt_nxt;

        always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
            if (!reconfig_reset_n) begin
                r_tx_st  <= TX_ANA;
                r_tx_cnt <= '0;
                r_rx_st  <= RX_ANA;
                r_rx_cnt <= '0;
            end else begin
                r_tx_st  <= w_tx_st_nxt;
                r_tx_cnt <= w_tx_cnt_nxt;
                r_rx_st  <= w_rx_st_nxt;
                r_rx_cnt <= w_rx_cnt_nxt;
            end
        end

        // Analog counter saturates so a late PLL lock or cal release exits on the next edge.
        always_comb begin
            w_tx_st_nxt  = r_tx_st;
            w_tx_cnt_nxt = r_tx_cnt;
            if (r_tx_req[g]) begin
                w_tx_st_nxt  = TX_ANA;
                w_tx_cnt_nxt = '0;
            end else begin
                case (r_tx_st)
                    TX_ANA: begin
                        if (r_tx_cnt >= CW'(T_ANALOG_CYC) && !w_txcal_s[g] && w_pll_s) begin
                            w_tx_st_nxt  = TX_DIG;
                            w_tx_cnt_nxt = '0;
                        end else if (r_tx_cnt < CW'(T_ANALOG_CYC)) begin
                            w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                        end
                    end
                    TX_DIG: begin
                        if (r_tx_cnt >= CW'(T_DIG_CYC - 1)) begin
                            w_tx_st_nxt  = TX_RDY;
                            w_tx_cnt_nxt = '0;
                        end else begin
                            w_tx_cnt_nxt = r_tx_cnt + 1'b1;
                        end
                    end
                    TX_RDY: begin
                        if (!w_pll_s) begin
                            w_tx_st_nxt  = TX_ANA;
                            w_tx_cnt_nxt = '0;
                        end
                    end
                    default: begin
                        w_tx_st_nxt  = TX_ANA;
                        w_tx_cnt_nxt = '0;
                    end
                endcase
            end
        end

        // Loss of lock only drops back to the lock wait; the analog front end stays up.
        always_comb begin
            w_rx_st_nxt  = r_rx_st;
            w_rx_cnt_nxt = r_rx_cnt;
            if (r_rx_req[g]) begin
                w_rx_st_nxt  = RX_ANA;
                w_rx_cnt_nxt = '0;
            end else begin
                case (r_rx_st)
                    RX_ANA: begin
                        if (r_rx_cnt >= CW'(T_ANALOG_CYC) && !w_rxcal_s[g]) begin
                            w_rx_st_nxt  = RX_LTD;
                            w_rx_cnt_nxt = '0;
                        end else if (r_rx_cnt < CW'(T_ANALOG_CYC)) begin
                            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                        end
                    end
                    RX_LTD: begin
                        if (r_rx_cnt >= CW'(T_LTD_CYC)) begin
                            w_rx_st_nxt  = RX_RDY;
                            w_rx_cnt_nxt = '0;
                        end else if (w_ltd_s[g]) begin
                            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                        end else begin
                            w_rx_cnt_nxt = '0;
                        end
                    end
                    RX_RDY: begin
                        if (!w_ltd_s[g]) begin
                            w_rx_st_nxt  = RX_LTD;
                            w_rx_cnt_nxt = '0;
                        end
                    end
                    default: begin
                        w_rx_st_nxt  = RX_ANA;
                        w_rx_cnt_nxt = '0;
                    end
                endcase
            end
        end

        assign tx_analogreset[g]  = (r_tx_st == TX_ANA);
        assign tx_digitalreset[g] = (r_tx_st != TX_RDY);
        assign tx_ready[g]        = (r_tx_st == TX_RDY);
        assign rx_analogreset[g]  = (r_rx_st == RX_ANA);
        assign rx_digitalreset[g] = (r_rx_st != RX_RDY);
        assign rx_ready[g]        = (r_rx_st == RX_RDY);
    end
endmodule
